// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MADDR_W = 16;

  localparam logic [XLEN-1:0] PC_RESET  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
  } skid_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory, redirect and decode-side signals of the fetch controller.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic                Stall;
  logic                BranchTaken;
  logic [XLEN-1:0]     BranchAddr;
  logic                MemReq;
  logic [MADDR_W-1:0]  MemAddr;
  logic                MemValid;
  logic [XLEN-1:0]     MemRdata;
  logic [XLEN-1:0]     InstrOut;
  logic                InstrValid;
  logic [XLEN-1:0]     PCAddrInc;

  // Controller side.
  modport master (
    input  Stall, BranchTaken, BranchAddr, MemValid, MemRdata,
    output MemReq, MemAddr, InstrOut, InstrValid, PCAddrInc
  );

  // Environment side (memory, decode, branch unit).
  modport slave (
    output Stall, BranchTaken, BranchAddr, MemValid, MemRdata,
    input  MemReq, MemAddr, InstrOut, InstrValid, PCAddrInc
  );

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  skid_entry_t din,
  output logic        valid,
  output skid_entry_t dout
);

  // Clear wins over load so a redirect always empties the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding request, one-word skid
// buffer for decode stalls, and response dropping after a redirect.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic            Clock,
  input  logic            nReset,
  fetch_ctrl_if.master    bus
);

  fetch_state_t      state, state_n;
  logic [XLEN-1:0]   fetch_pc, pc_n;
  logic [XLEN-1:0]   instr_q, instr_n;
  logic              valid_q, valid_n;
  logic [XLEN-1:0]   inc_q, inc_n;
  logic              req_q, req_n;

  logic              skid_load, skid_clear, skid_valid;
  skid_entry_t       skid_din, skid_dout;

  logic [XLEN-1:0]   pc_plus;
  logic [XLEN-1:0]   branch_target;
  logic              out_free;
  logic              mem_done;

  assign pc_plus       = fetch_pc + PC_STEP;
  assign branch_target = bus.BranchAddr & 32'hFFFF_FFFC;
  assign out_free      = !valid_q || !bus.Stall;
  // Responses only count while a request is actually on the bus.
  assign mem_done      = req_q && bus.MemValid;

  assign skid_din = '{instr: bus.MemRdata, addr: fetch_pc};

  fetch_skid u_skid (
    .clk   (Clock),
    .rst_n (nReset),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (skid_din),
    .valid (skid_valid),
    .dout  (skid_dout)
  );

  // Next-state, next-PC and next-output selection; redirect beats everything.
  always_comb begin
    state_n    = state;
    pc_n       = fetch_pc;
    instr_n    = instr_q;
    inc_n      = inc_q;
    valid_n    = valid_q && bus.Stall;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (bus.BranchTaken) begin
      pc_n       = branch_target;
      valid_n    = 1'b0;
      skid_clear = 1'b1;
      state_n    = (state == S_REQ && req_q && !bus.MemValid) ? S_DROP : S_REQ;
    end else begin
      unique case (state)
        S_REQ: begin
          if (mem_done) begin
            pc_n = pc_plus;
            if (out_free) begin
              instr_n = bus.MemRdata;
              inc_n   = pc_plus;
              valid_n = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_n   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!bus.Stall && skid_valid) begin
            instr_n    = skid_dout.instr;
            inc_n      = skid_dout.addr + PC_STEP;
            valid_n    = 1'b1;
            skid_clear = 1'b1;
            state_n    = S_REQ;
          end
        end
        S_DROP: begin
          if (bus.MemValid) state_n = S_REQ;
        end
        default: state_n = S_REQ;
      endcase
    end

    req_n = (state_n == S_REQ);
  end

  // Register state, PC and all decode/memory-facing outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= S_REQ;
      fetch_pc <= PC_RESET;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      inc_q    <= PC_RESET + PC_STEP;
      req_q    <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      instr_q  <= instr_n;
      valid_q  <= valid_n;
      inc_q    <= inc_n;
      req_q    <= req_n;
    end
  end

  assign bus.MemReq     = req_q;
  assign bus.MemAddr    = fetch_pc[MADDR_W-1:0];
  assign bus.InstrOut   = instr_q;
  assign bus.InstrValid = valid_q;
  assign bus.PCAddrInc  = inc_q;

endmodule
